mem_bus_ctrl: RTL and testbench

Memory bus responder for the SRP16 core: the far end of the `mem_read`/`mem_write` strobes issued by the control decoder. It accepts 16-bit word accesses from the internal address and data buses. It serialises each access into two byte-wide cycles on an external asynchronous SRAM, with a programmable number of wait states, and signals completion with a one-cycle `done` pulse.

---
 rtl/srp16_pkg.sv | 21 ++
 rtl/mem_bus_ctrl_wait_counter.sv | 37 +++
 rtl/mem_bus_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/srp16_pkg.sv
// Shared types and constants for the SRP16 memory bus responder.
package srp16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int BYTE_W = 8;
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // Address of the high byte of a word; wraps at the top of the address space.
  function automatic logic [ADDR_W-1:0] hi_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_wait_counter.sv
// Loadable down-counter timing one byte phase; exposes current and next zero flags.
module wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         zero_next
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero      = (cnt_q == '0);
  assign zero_next = (cnt_d == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// SRP16 memory bus responder: splits 16-bit accesses into two byte cycles on an async SRAM.
// Optional byte-only accesses are enabled with `define MEM_BUS_CTRL_BYTE_EN.
module mem_bus_ctrl
  import srp16_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] abus,
  input  logic [DATA_W-1:0] dbus_in,
`ifdef MEM_BUS_CTRL_BYTE_EN
  input  logic              byte_sel,
`endif
  output logic [DATA_W-1:0] dbus_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [BYTE_W-1:0] sram_wdata,
  input  logic [BYTE_W-1:0] sram_rdata,
  output logic              sram_oe,
  output logic              sram_we
);

  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(WAIT_CYCLES);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              bsel_q;
  logic [BYTE_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] dbus_out_q, dbus_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [BYTE_W-1:0] sram_wdata_q, sram_wdata_d;
  logic              sram_oe_q, sram_oe_d;
  logic              sram_we_q, sram_we_d;

  logic cnt_load;
  logic cnt_dec;
  logic wcnt_zero;
  logic wcnt_zero_next;

`ifdef MEM_BUS_CTRL_BYTE_EN
  logic bsel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      bsel_q <= 1'b0;
    end else begin
      bsel_q <= bsel_d;
    end
  end
`else
  assign bsel_q = 1'b0;
`endif

  wait_counter #(
    .W(WCNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_LD),
    .dec      (cnt_dec),
    .zero     (wcnt_zero),
    .zero_next(wcnt_zero_next)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = wr_q;
    lo_d       = lo_q;
    dbus_out_d = dbus_out_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
`ifdef MEM_BUS_CTRL_BYTE_EN
    bsel_d     = bsel_q;
`endif

    case (state_q)
      IDLE: begin
        // Write takes priority when both strobes arrive together.
        if (mem_read || mem_write) begin
          addr_d   = abus;
          data_d   = dbus_in;
          wr_d     = mem_write;
          cnt_load = 1'b1;
          state_d  = LO;
`ifdef MEM_BUS_CTRL_BYTE_EN
          bsel_d   = byte_sel;
`endif
        end
      end
      LO: begin
        if (wcnt_zero) begin
          if (!wr_q) begin
            lo_d = sram_rdata;
          end
          if (bsel_q) begin
            if (!wr_q) begin
              dbus_out_d = {{(DATA_W-BYTE_W){1'b0}}, sram_rdata};
            end
            state_d = DONE;
          end else begin
            cnt_load = 1'b1;
            state_d  = HI;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HI: begin
        if (wcnt_zero) begin
          if (!wr_q) begin
            dbus_out_d = {sram_rdata, lo_q};
          end
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    busy_d       = (state_d == LO) || (state_d == HI);
    done_d       = (state_d == DONE);
    sram_oe_d    = busy_d && !wr_d;
    sram_we_d    = busy_d && wr_d && wcnt_zero_next;
    sram_addr_d  = (state_d == HI) ? hi_addr(addr_d) : addr_d;
    sram_wdata_d = '0;
    if (sram_we_d) begin
      sram_wdata_d = (state_d == HI) ? data_d[DATA_W-1:BYTE_W] : data_d[BYTE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      lo_q         <= '0;
      dbus_out_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_oe_q    <= 1'b0;
      sram_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
      lo_q         <= lo_d;
      dbus_out_q   <= dbus_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_oe_q    <= sram_oe_d;
      sram_we_q    <= sram_we_d;
    end
  end

  assign dbus_out   = dbus_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_oe    = sram_oe_q;
  assign sram_we    = sram_we_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (WAIT_CYCLES=1 and 0) share one SRAM model.
`define CHK(tag, obs, exp) begin tests++; assert ((obs) === (exp)) else begin fails++; $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp); end end

module tb_mem_bus_ctrl;

  localparam int W0 = 1;
  localparam int W1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        r_read, r_write, r_bsel;
  logic [15:0] abus, dbus_in;

  logic        rd0, wr0, rd1, wr1;
  logic [15:0] dout0, dout1, addr0, addr1;
  logic        busy0, busy1, done0, done1, oe0, oe1, we0, we1;
  logic [7:0]  wd0, wd1, rdata0, rdata1;

  logic [15:0] dout_m, addr_m;
  logic        busy_m, done_m, oe_m, we_m;
  logic [7:0]  wd_m;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] cur_dout [2];
  logic        bk_we;
  logic [15:0] bk_addr;
  logic [7:0]  bk_data;

  assign rd0 = r_read & ~sel;
  assign wr0 = r_write & ~sel;
  assign rd1 = r_read & sel;
  assign wr1 = r_write & sel;

  mem_bus_ctrl #(.WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .abus(abus), .dbus_in(dbus_in),
`ifdef MEM_BUS_CTRL_BYTE_EN
    .byte_sel(r_bsel),
`endif
    .dbus_out(dout0), .busy(busy0), .done(done0), .sram_addr(addr0), .sram_wdata(wd0),
    .sram_rdata(rdata0), .sram_oe(oe0), .sram_we(we0)
  );

  mem_bus_ctrl #(.WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .abus(abus), .dbus_in(dbus_in),
`ifdef MEM_BUS_CTRL_BYTE_EN
    .byte_sel(r_bsel),
`endif
    .dbus_out(dout1), .busy(busy1), .done(done1), .sram_addr(addr1), .sram_wdata(wd1),
    .sram_rdata(rdata1), .sram_oe(oe1), .sram_we(we1)
  );

  // Asynchronous SRAM: combinational read, write captured while the strobe is high.
  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    if (we0)   mem[addr0]   <= wd0;
    if (we1)   mem[addr1]   <= wd1;
  end
  assign rdata0 = mem[addr0];
  assign rdata1 = mem[addr1];

  assign dout_m = sel ? dout1 : dout0;
  assign addr_m = sel ? addr1 : addr0;
  assign busy_m = sel ? busy1 : busy0;
  assign done_m = sel ? done1 : done0;
  assign oe_m   = sel ? oe1   : oe0;
  assign we_m   = sel ? we1   : we0;
  assign wd_m   = sel ? wd1   : wd0;

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(negedge clk);
    bk_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    `CHK({tag, "_rst"}, {dout_m, busy_m, done_m, addr_m, wd_m, oe_m, we_m}, 45'd0)
  endtask

  // One access. poke2 re-issues a read strobe mid-access; rst_at>0 resets at that cycle.
  task automatic access(input bit wr, input bit rd, input logic [15:0] a, input logic [15:0] d,
                        input bit bs, input bit poke2, input int rst_at);
    int          ph, nph, lat, cyc_bad, post_bad, idx;
    bit          is_rd, exp_we;
    logic [15:0] a1, exp_addr, exp_dout;
    logic [7:0]  exp_wd;
    idx      = sel ? 1 : 0;
    ph       = (sel ? W1 : W0) + 1;
    nph      = bs ? 1 : 2;
    lat      = ph * nph + 1;
    is_rd    = rd & ~wr;
    a1       = a + 16'd1;
    cyc_bad  = 0;
    post_bad = 0;
    exp_dout = cur_dout[idx];
    if (is_rd) exp_dout = bs ? {8'h00, ref_mem[a]} : {ref_mem[a1], ref_mem[a]};

    @(negedge clk);
    r_read = rd; r_write = wr; abus = a; dbus_in = d; r_bsel = bs;
    for (int n = 1; n <= lat + 3; n++) begin
      @(negedge clk);
      if (n == 1) begin r_read = 1'b0; r_write = 1'b0; end
      if (poke2 && n == 2) r_read = 1'b1;
      if (poke2 && n == 3) r_read = 1'b0;
      if (rst_at != 0 && n == rst_at + 1) begin
        `CHK("cycles", cyc_bad, 0)
        chk_reset_vals("abort");
        rst = 1'b0;
        r_read = 1'b0;
        if (wr) begin
          if (ph <= rst_at) ref_mem[a] = d[7:0];
          if (nph == 2 && 2 * ph <= rst_at) ref_mem[a1] = d[15:8];
        end
        cur_dout[0] = 16'h0;
        cur_dout[1] = 16'h0;
        $display("[TB] sel=%0d wr=%0d addr=%h data=%h aborted at cycle %0d", sel, wr, a, d, rst_at);
        return;
      end
      if (n < lat) begin
        exp_addr = (n <= ph) ? a : a1;
        exp_we   = wr && (n == ph || (nph == 2 && n == 2 * ph));
        exp_wd   = exp_we ? ((n <= ph) ? d[7:0] : d[15:8]) : 8'h00;
        if (busy_m !== 1'b1 || done_m !== 1'b0 || oe_m !== is_rd || we_m !== exp_we ||
            wd_m !== exp_wd || addr_m !== exp_addr || dout_m !== cur_dout[idx])
          cyc_bad++;
      end else if (n == lat) begin
        `CHK("done", {done_m, busy_m, oe_m, we_m}, 4'b1000)
        `CHK("dbus_out", dout_m, exp_dout)
      end else begin
        if (done_m !== 1'b0 || busy_m !== 1'b0) post_bad++;
      end
      if (rst_at != 0 && n == rst_at) rst = 1'b1;
    end
    `CHK("cycles", cyc_bad, 0)
    `CHK("idle_after", post_bad, 0)
    if (wr) begin
      ref_mem[a] = d[7:0];
      if (!bs) ref_mem[a1] = d[15:8];
    end
    cur_dout[idx] = exp_dout;
    $display("[TB] sel=%0d wr=%0d rd=%0d bs=%0d addr=%h wdata=%h dbus_out=%h", sel, wr, rd, bs, a, d, dout_m);
  endtask

  initial begin
    logic [15:0] ra, rd_v;
    bit          rwr, rbs;
    rst = 1'b1; sel = 1'b0; r_read = 1'b0; r_write = 1'b0; r_bsel = 1'b0;
    abus = '0; dbus_in = '0; bk_we = 1'b0; bk_addr = '0; bk_data = '0;
    cur_dout[0] = 16'h0; cur_dout[1] = 16'h0;
    repeat (3) @(negedge clk);
    chk_reset_vals("w1");
    sel = 1'b1;
    #1 chk_reset_vals("w0");
    sel = 1'b0;
    rst = 1'b0;

    // Directed word read.
    poke(16'h0010, 8'h34); poke(16'h0011, 8'h12);
    access(1'b0, 1'b1, 16'h0010, 16'h0, 1'b0, 1'b0, 0);
    `CHK("tp_read", dout_m, 16'h1234)

    // Write then read back.
    access(1'b1, 1'b0, 16'h0020, 16'hBEEF, 1'b0, 1'b0, 0);
    `CHK("tp_wr_lo", mem[16'h0020], 8'hEF)
    `CHK("tp_wr_hi", mem[16'h0021], 8'hBE)
    access(1'b0, 1'b1, 16'h0020, 16'h0, 1'b0, 1'b0, 0);
    `CHK("tp_readback", dout_m, 16'hBEEF)

    // Address wrap.
    poke(16'hFFFF, 8'hAA); poke(16'h0000, 8'h55);
    access(1'b0, 1'b1, 16'hFFFF, 16'h0, 1'b0, 1'b0, 0);
    `CHK("tp_wrap", dout_m, 16'h55AA)

    // Both strobes: write wins, read data untouched.
    access(1'b1, 1'b1, 16'h0030, 16'h9A5C, 1'b0, 1'b0, 0);
    `CHK("tp_both_dout", dout_m, 16'h55AA)
    `CHK("tp_both_mem", {mem[16'h0031], mem[16'h0030]}, 16'h9A5C)

    // Ignored strobe during busy, then reset in the HI phase of a write.
    poke(16'h0040, 8'h00); poke(16'h0041, 8'h66);
    access(1'b1, 1'b0, 16'h0040, 16'hC3A5, 1'b0, 1'b1, 3);
    access(1'b0, 1'b1, 16'h0040, 16'h0, 1'b0, 1'b0, 0);
    `CHK("tp_abort_partial", dout_m, 16'h66A5)

    // Zero wait states.
    sel = 1'b1;
    access(1'b1, 1'b0, 16'h0050, 16'h1357, 1'b0, 1'b0, 0);
    access(1'b0, 1'b1, 16'h0050, 16'h0, 1'b0, 1'b1, 0);
    `CHK("tp_w0_read", dout_m, 16'h1357)
`ifdef MEM_BUS_CTRL_BYTE_EN
    poke(16'h0005, 8'h7F); poke(16'h0006, 8'hE1);
    access(1'b0, 1'b1, 16'h0005, 16'h0, 1'b1, 1'b0, 0);
    `CHK("tp_byte_read", dout_m, 16'h007F)
    access(1'b1, 1'b0, 16'h0006, 16'h4422, 1'b1, 1'b0, 0);
    `CHK("tp_byte_write", {mem[16'h0007], mem[16'h0006]}, {ref_mem[16'h0007], 8'h22})
`endif

    // Randomised accesses against the reference memory.
    for (int i = 0; i < 24; i++) poke(16'h0100 + 16'(i), 8'($urandom));
    for (int i = 0; i < 16; i++) poke(16'hFFF8 + 16'(i), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      sel  = 1'($urandom);
      ra   = $urandom_range(0, 1) ? (16'h0100 + 16'($urandom_range(0, 22)))
                                  : (16'hFFF8 + 16'($urandom_range(0, 14)));
      rd_v = 16'($urandom);
      rwr  = 1'($urandom);
`ifdef MEM_BUS_CTRL_BYTE_EN
      rbs  = 1'($urandom);
`else
      rbs  = 1'b0;
`endif
      access(rwr, ~rwr | 1'($urandom), ra, rd_v, rbs, 1'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
